clz_pipeline_unit: RTL

CLZ_PIPELINE_UNIT -- requirements
Module: clz_pipeline_unit

---
 rtl/clz_pipeline_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/clz_pipeline_unit.sv
// Two-stage count-leading-zeros unit with a valid/ready handshake on both sides.
// S1 analyses each nibble, and S2 combines the per-nibble results into the final count.
module clz_pipeline_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [5:0]  lz_count_o,
   output logic        is_zero_o,
   output logic        valid_o,
   input  logic        ready_i,
   input  logic        flush_i
);

   function automatic logic [1:0] nibble_lz(input logic [3:0] n);
      logic [1:0] r;
      casez (n)
         4'b1???: r = 2'd0;
         4'b01??: r = 2'd1;
         4'b001?: r = 2'd2;
         default: r = 2'd3;
      endcase
      return r;
   endfunction

   // The result is the number of all-zero nibbles before the first non-zero nibble, counted from bit 0.
   function automatic logic [2:0] boundary_idx(input logic [7:0] nz);
      logic [2:0] r;
      casez (nz)
         8'b???????0: r = 3'd0;
         8'b??????01: r = 3'd1;
         8'b?????011: r = 3'd2;
         8'b????0111: r = 3'd3;
         8'b???01111: r = 3'd4;
         8'b??011111: r = 3'd5;
         8'b?0111111: r = 3'd6;
         8'b01111111: r = 3'd7;
         default:     r = 3'd0;
      endcase
      return r;
   endfunction

   logic            s1_valid_r;
   logic [7:0]      s1_nz_r;
   logic [7:0][1:0] s1_loc_r;
   logic            s2_valid_r;
   logic [5:0]      lz_count_r;
   logic            is_zero_r;

   logic            s2_adv_s;
   logic            s1_adv_s;
   logic            in_xfer_s;
   logic [7:0]      nz_s;
   logic [7:0][1:0] loc_s;
   logic [2:0]      k_s;
   logic            all_zero_s;
   logic [5:0]      lz_next_s;

   assign s2_adv_s  = !s2_valid_r || ready_i;
   assign s1_adv_s  = !s1_valid_r || s2_adv_s;
   assign ready_o   = !rst_i && !flush_i && s1_adv_s;
   assign in_xfer_s = valid_i && ready_o;

   assign valid_o    = s2_valid_r;
   assign lz_count_o = lz_count_r;
   assign is_zero_o  = is_zero_r;

   // Per-nibble zero flag and local leading-zero count of the incoming operand.
   always_comb begin
      nz_s  = 8'h00;
      loc_s = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         nz_s[i]  = (data_i[31-4*i -: 4] == 4'b0000);
         loc_s[i] = nibble_lz(data_i[31-4*i -: 4]);
      end
   end

   // Combine the nibble results; an all-zero operand saturates at 32.
   always_comb begin
      k_s        = boundary_idx(s1_nz_r);
      all_zero_s = (s1_nz_r == 8'hFF);
      if (all_zero_s) begin
         lz_next_s = 6'd32;
      end else begin
         lz_next_s = {1'b0, k_s, s1_loc_r[k_s]};
      end
   end

   // Stage 1 registers: loaded only by an accepted operand, held while blocked.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_r <= 1'b0;
         s1_nz_r    <= 8'h00;
         s1_loc_r   <= 16'h0000;
      end else if (flush_i) begin
         s1_valid_r <= 1'b0;
      end else if (s1_adv_s) begin
         s1_valid_r <= in_xfer_s;
         if (in_xfer_s) begin
            s1_nz_r  <= nz_s;
            s1_loc_r <= loc_s;
         end
      end
   end

   // Stage 2 registers drive the outputs directly, so they stay stable under backpressure.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s2_valid_r <= 1'b0;
         lz_count_r <= 6'd0;
         is_zero_r  <= 1'b0;
      end else if (flush_i) begin
         s2_valid_r <= 1'b0;
      end else if (s2_adv_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            lz_count_r <= lz_next_s;
            is_zero_r  <= all_zero_s;
         end
      end
   end

endmodule
